// File: rtl/pdp8_io_pkg.sv
// Shared types and constants for PDP-8 positive I/O bus peripherals.
package pdp8_io_pkg;
    localparam int WORD_W   = 12;
    localparam int DEV_W    = 6;
    localparam int IOP1_BIT = 0;
    localparam int IOP2_BIT = 1;
    localparam int IOP4_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        BUSY = 2'd2
    } state_e;
endpackage

// File: rtl/iop_edge_det.sv
// Registered rising-edge detector for the three IOP levels; the pulse appears one cycle after the rise.
module iop_edge_det (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [2:0] lvl_i,
    output logic [2:0] rise_o
);
    logic [2:0] lvl_q;
    logic [2:0] rise_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            lvl_q  <= '0;
            rise_q <= '0;
        end else begin
            lvl_q  <= lvl_i;
            rise_q <= lvl_i & ~lvl_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/io_out_buffer.sv
// Bus-to-device output buffer: IOT decode, word capture, valid/ready hand-off, done flag and skip.
// Optional interrupt enable (6xx5) and int_rq_n are built when IO_OUT_INTERRUPT_EN is defined.
module io_out_buffer
    import pdp8_io_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEV_CODE   = 6'o04,
    parameter int               DONE_DELAY = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              iot,
    input  logic [DEV_W-1:0]  mb_dev,
    input  logic              iop1,
    input  logic              iop2,
    input  logic              iop4,
    input  logic [0:WORD_W-1] bac,
    output logic              skip_n,
    output logic [0:WORD_W-1] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              flag,
    output logic              busy,
    output logic              int_rq_n
);
    localparam int CNT_W = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:WORD_W-1] dout_q, dout_d;
    logic              flag_q, flag_d;
    logic              sel, srst_n, ld, done;
    logic [2:0]        iop_lvl, iop_rise;

    assign sel    = iot & (mb_dev == DEV_CODE);
    assign srst_n = reset_n & ~init;

    // Qualifying with sel before edge detection means a pulse only counts while this device is addressed.
    always_comb begin
        iop_lvl           = '0;
        iop_lvl[IOP1_BIT] = iop1 & sel;
        iop_lvl[IOP2_BIT] = iop2 & sel;
        iop_lvl[IOP4_BIT] = iop4 & sel;
    end

    iop_edge_det u_edge (
        .clk    (clk),
        .clr_n  (srst_n),
        .lvl_i  (iop_lvl),
        .rise_o (iop_rise)
    );

`ifdef IO_OUT_INTERRUPT_EN
    logic p1seen_q, ie_q, int_rq_n_q;

    // IOP4 after IOP1 within one IOT is 6xx5: it writes the enable instead of loading data.
    assign ld = iop_rise[IOP4_BIT] & ~p1seen_q;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            p1seen_q   <= 1'b0;
            ie_q       <= 1'b0;
            int_rq_n_q <= 1'b1;
        end else begin
            if (!sel)
                p1seen_q <= 1'b0;
            else if (iop_rise[IOP1_BIT])
                p1seen_q <= 1'b1;
            if (iop_rise[IOP4_BIT] && p1seen_q)
                ie_q <= bac[WORD_W-1];
            int_rq_n_q <= ~(flag_q & ie_q);
        end
    end

    assign int_rq_n = int_rq_n_q;
`else
    assign ld       = iop_rise[IOP4_BIT];
    assign int_rq_n = 1'b1;
`endif

    // A reload during BUSY abandons the running countdown, so it suppresses completion.
    assign done = (state_q == BUSY) && (cnt_q == '0) && !ld;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            PEND: if (dout_ready) begin
                state_d = BUSY;
                cnt_d   = CNT_W'(DONE_DELAY - 1);
            end
            BUSY: if (cnt_q == '0) state_d = IDLE;
                  else             cnt_d   = cnt_q - CNT_W'(1);
            default: ;
        endcase
        if (ld) begin
            state_d = PEND;
            dout_d  = bac;
        end
        flag_d = done | (flag_q & ~iop_rise[IOP2_BIT]);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            flag_q  <= flag_d;
        end
    end

    assign skip_n     = ~(sel & iop1 & flag_q);
    assign dout       = dout_q;
    assign dout_valid = (state_q == PEND);
    assign flag       = flag_q;
    assign busy       = (state_q != IDLE);
endmodule
